// File: rtl/wb_pkg.sv
// Shared types for the Wishbone command master: command word, response status
// and master FSM state encoding.
package wb_pkg;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_cmd_t;

  typedef enum logic [1:0] {
    WB_OK              = 2'd0,
    WB_ERR             = 2'd1,
    WB_TIMEOUT         = 2'd2,
    WB_RETRY_EXHAUSTED = 2'd3
  } wb_status_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_BACKOFF = 2'd2,
    ST_RESP    = 2'd3
  } mst_state_e;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Wishbone B3 classic bus between the command master and the SoC slave
// register port.
interface wb_cmd_master_if;
  logic [31:0] p_wb_ADR_O;
  logic [31:0] p_wb_DAT_O;
  logic [31:0] p_wb_DAT_I;
  logic [3:0]  p_wb_SEL_O;
  logic        p_wb_WE_O;
  logic        p_wb_CYC_O;
  logic        p_wb_STB_O;
  logic        p_wb_LOCK_O;
  logic        p_wb_ACK_I;
  logic        p_wb_ERR_I;
  logic        p_wb_RTY_I;

  modport master (
    output p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_WE_O,
           p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O,
    input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
  );

  modport slave (
    input  p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_WE_O,
           p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O,
    output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
  );
endinterface

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so that full
// and empty are told apart without a separate counter.
module wb_cmd_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_cmd_t din,
  input  logic    pop,
  output wb_cmd_t dout,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  wb_cmd_t     mem_r [DEPTH];
  logic        push_s;
  logic        pop_s;

  assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty  = (wr_ptr_r == rd_ptr_r);
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone B3 classic single-cycle master: queues local commands, runs one bus
// cycle per command with retry/timeout handling, returns one response each.
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        p_clk,
  input  logic        p_resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic        busy,
  wb_cmd_master_if.master wb
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT);

  mst_state_e  state_r;
  wb_status_e  status_r;
  logic        cyc_r, stb_r, we_r, rsp_valid_r;
  logic [31:0] adr_r, dat_r, rsp_dat_r;
  logic [3:0]  sel_r;
  logic [RW-1:0] attempt_r;
  logic [TW-1:0] tmo_r;
  wb_cmd_t     push_cmd_s, head_s;
  logic        full_s, empty_s, pop_s;

  assign push_cmd_s = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
  assign pop_s      = (state_r == ST_IDLE) && !empty_s;

  wb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (p_clk),
    .rst_n (p_resetn),
    .push  (cmd_valid),
    .din   (push_cmd_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign cmd_ready      = !full_s;
  assign busy           = !empty_s || (state_r != ST_IDLE);
  assign rsp_valid      = rsp_valid_r;
  assign rsp_dat        = rsp_dat_r;
  assign rsp_status     = status_r;
  assign wb.p_wb_ADR_O  = adr_r;
  assign wb.p_wb_DAT_O  = dat_r;
  assign wb.p_wb_SEL_O  = sel_r;
  assign wb.p_wb_WE_O   = we_r;
  assign wb.p_wb_CYC_O  = cyc_r;
  assign wb.p_wb_STB_O  = stb_r;
  assign wb.p_wb_LOCK_O = 1'b0;

  // Master FSM; terminators are only looked at in REQ, ERR beats ACK beats RTY
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_r     <= ST_IDLE;
      status_r    <= WB_OK;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      rsp_valid_r <= 1'b0;
      adr_r       <= 32'h0;
      dat_r       <= 32'h0;
      rsp_dat_r   <= 32'h0;
      sel_r       <= 4'h0;
      attempt_r   <= '0;
      tmo_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            adr_r     <= head_s.adr;
            dat_r     <= head_s.dat;
            sel_r     <= head_s.sel;
            we_r      <= head_s.we;
            cyc_r     <= 1'b1;
            stb_r     <= 1'b1;
            attempt_r <= '0;
            tmo_r     <= '0;
            state_r   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (wb.p_wb_ERR_I || wb.p_wb_ACK_I) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
            status_r    <= wb.p_wb_ERR_I ? WB_ERR : WB_OK;
            rsp_dat_r   <= (wb.p_wb_ERR_I || we_r) ? 32'h0 : wb.p_wb_DAT_I;
          end else if (wb.p_wb_RTY_I) begin
            cyc_r <= 1'b0;
            stb_r <= 1'b0;
            if (attempt_r + RW'(1) == RETRY_LAST) begin
              rsp_valid_r <= 1'b1;
              rsp_dat_r   <= 32'h0;
              status_r    <= WB_RETRY_EXHAUSTED;
              state_r     <= ST_RESP;
            end else begin
              attempt_r <= attempt_r + RW'(1);
              state_r   <= ST_BACKOFF;
            end
          end else if (tmo_r + TW'(1) == TMO_LAST) begin
            cyc_r       <= 1'b0;
            stb_r       <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_dat_r   <= 32'h0;
            status_r    <= WB_TIMEOUT;
            state_r     <= ST_RESP;
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_BACKOFF: begin
          tmo_r   <= '0;
          cyc_r   <= 1'b1;
          stb_r   <= 1'b1;
          state_r <= ST_REQ;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          cyc_r       <= 1'b0;
          stb_r       <= 1'b0;
          rsp_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small behavioural Wishbone slave
// whose termination behaviour is selected per step.
module tb_wb_cmd_master;
  import wb_pkg::*;

  typedef enum int {M_ACK, M_RTY2, M_RTY, M_NONE, M_ERRACK} slave_mode_t;

  logic        p_clk = 1'b0;
  logic        p_resetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_adr = 32'h0, cmd_dat = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        cmd_ready, rsp_valid, busy;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;

  slave_mode_t mode = M_ACK;
  int          rty_given = 0, rty_base = 0, stb_cycles = 0, stb_pulses = 0;
  logic        stb_prev = 1'b0;
  logic [31:0] slave_mem = 32'h0;
  int          vectors = 0, miscompares = 0;

  always #5 p_clk = ~p_clk;

  wb_cmd_master_if wb_bus ();

  wb_cmd_master #(.FIFO_DEPTH(4), .MAX_RETRY(3), .TIMEOUT(16)) dut (
    .p_clk      (p_clk),
    .p_resetn   (p_resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_dat    (cmd_dat),
    .cmd_sel    (cmd_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dat    (rsp_dat),
    .rsp_status (rsp_status),
    .busy       (busy),
    .wb         (wb_bus)
  );

  // Behavioural slave: address 0x100 is a storage word, others read as ~adr
  always_comb begin
    wb_bus.p_wb_ACK_I = 1'b0;
    wb_bus.p_wb_ERR_I = 1'b0;
    wb_bus.p_wb_RTY_I = 1'b0;
    wb_bus.p_wb_DAT_I = (wb_bus.p_wb_ADR_O == 32'h100) ? slave_mem : ~wb_bus.p_wb_ADR_O;
    if (wb_bus.p_wb_STB_O) begin
      case (mode)
        M_ACK:    wb_bus.p_wb_ACK_I = 1'b1;
        M_RTY2:   if (rty_given - rty_base < 2) wb_bus.p_wb_RTY_I = 1'b1;
                  else wb_bus.p_wb_ACK_I = 1'b1;
        M_RTY:    wb_bus.p_wb_RTY_I = 1'b1;
        M_ERRACK: begin
          wb_bus.p_wb_ERR_I = 1'b1;
          wb_bus.p_wb_ACK_I = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus monitor and slave storage
  always @(posedge p_clk) begin
    stb_prev <= wb_bus.p_wb_STB_O;
    if (wb_bus.p_wb_STB_O && !stb_prev) stb_pulses <= stb_pulses + 1;
    if (wb_bus.p_wb_STB_O) stb_cycles <= stb_cycles + 1;
    if (wb_bus.p_wb_STB_O && wb_bus.p_wb_RTY_I) rty_given <= rty_given + 1;
    if (wb_bus.p_wb_STB_O && wb_bus.p_wb_ACK_I && wb_bus.p_wb_WE_O) slave_mem <= wb_bus.p_wb_DAT_O;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel);
    int n;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge p_clk);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge p_clk);
    @(negedge p_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(posedge p_clk);
      @(negedge p_clk);
      n++;
    end
    cycles = n;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge p_clk);
    @(negedge p_clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, p0, c0;
    logic [31:0] exp_dat;
    logic seen;

    // Reset values
    repeat (3) @(negedge p_clk);
    check("rst_cyc", 32'(wb_bus.p_wb_CYC_O), 32'd0);
    check("rst_stb", 32'(wb_bus.p_wb_STB_O), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_adr", wb_bus.p_wb_ADR_O, 32'h0);
    check("rst_status", 32'(rsp_status), 32'd0);
    p_resetn = 1'b1;
    @(negedge p_clk);

    // Write to always-ACK slave, with one-cycle STB latency
    mode = M_ACK; p0 = stb_pulses; c0 = stb_cycles;
    send_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    @(posedge p_clk); @(negedge p_clk);
    check("wr_stb_high", 32'(wb_bus.p_wb_STB_O), 32'd1);
    check("wr_we", 32'(wb_bus.p_wb_WE_O), 32'd1);
    check("wr_dat_o", wb_bus.p_wb_DAT_O, 32'hDEADBEEF);
    check("wr_adr", wb_bus.p_wb_ADR_O, 32'h100);
    check("wr_lock", 32'(wb_bus.p_wb_LOCK_O), 32'd0);
    @(posedge p_clk); @(negedge p_clk);
    check("wr_stb_low", 32'(wb_bus.p_wb_STB_O), 32'd0);
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_status", 32'(rsp_status), 32'd0);
    check("wr_rsp_dat", rsp_dat, 32'h0);
    check("wr_stb_cycles", 32'(stb_cycles - c0), 32'd1);
    consume();
    check("wr_rsp_cleared", 32'(rsp_valid), 32'd0);

    // Read back the written word
    send_cmd(1'b0, 32'h100, 32'h0, 4'hF);
    wait_rsp(n);
    check("rd_latency", 32'(n), 32'd2);
    check("rd_dat", rsp_dat, 32'hDEADBEEF);
    check("rd_status", 32'(rsp_status), 32'd0);
    consume();

    // Two retries then ACK
    mode = M_RTY2; rty_base = rty_given; p0 = stb_pulses; c0 = stb_cycles;
    send_cmd(1'b0, 32'h104, 32'h0, 4'hF);
    wait_rsp(n);
    check("rty2_latency", 32'(n), 32'd6);
    check("rty2_pulses", 32'(stb_pulses - p0), 32'd3);
    check("rty2_stb_cycles", 32'(stb_cycles - c0), 32'd3);
    check("rty2_status", 32'(rsp_status), 32'd0);
    check("rty2_dat", rsp_dat, 32'hFFFFFEFB);
    consume();

    // Retry every attempt
    mode = M_RTY; p0 = stb_pulses;
    send_cmd(1'b0, 32'h108, 32'h0, 4'hF);
    wait_rsp(n);
    check("rtyx_latency", 32'(n), 32'd6);
    check("rtyx_pulses", 32'(stb_pulses - p0), 32'd3);
    check("rtyx_status", 32'(rsp_status), 32'd3);
    check("rtyx_dat", rsp_dat, 32'h0);
    consume();

    // Silent slave times out
    mode = M_NONE; p0 = stb_pulses; c0 = stb_cycles;
    send_cmd(1'b1, 32'h10C, 32'h12345678, 4'h3);
    wait_rsp(n);
    check("tmo_latency", 32'(n), 32'd17);
    check("tmo_stb_cycles", 32'(stb_cycles - c0), 32'd16);
    check("tmo_pulses", 32'(stb_pulses - p0), 32'd1);
    check("tmo_status", 32'(rsp_status), 32'd2);
    consume();

    // ERR and ACK together: ERR wins
    mode = M_ERRACK;
    send_cmd(1'b0, 32'h110, 32'h0, 4'hF);
    wait_rsp(n);
    check("err_latency", 32'(n), 32'd2);
    check("err_status", 32'(rsp_status), 32'd1);
    check("err_dat", rsp_dat, 32'h0);
    consume();

    // Backpressure: 4 queued + 1 in flight fills the master
    mode = M_ACK;
    for (int i = 0; i < 5; i++) send_cmd(1'b0, 32'h200 + 32'(4 * i), 32'h0, 4'hF);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(n);
      exp_dat = ~(32'h200 + 32'(4 * i));
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_order_dat", rsp_dat, exp_dat);
      check("bp_status", 32'(rsp_status), 32'd0);
      consume();
    end
    repeat (2) @(negedge p_clk);
    check("bp_idle", 32'(busy), 32'd0);

    // Reset while STB is high drops everything
    mode = M_NONE;
    send_cmd(1'b1, 32'h300, 32'hA5A5A5A5, 4'hF);
    send_cmd(1'b1, 32'h304, 32'h5A5A5A5A, 4'hF);
    check("rst_mid_stb_before", 32'(wb_bus.p_wb_STB_O), 32'd1);
    #2 p_resetn = 1'b0;
    #1;
    check("rst_mid_stb", 32'(wb_bus.p_wb_STB_O), 32'd0);
    check("rst_mid_cyc", 32'(wb_bus.p_wb_CYC_O), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge p_clk);
    p_resetn = 1'b1;
    mode = M_ACK;
    rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge p_clk);
      seen = seen | rsp_valid | wb_bus.p_wb_STB_O | busy;
    end
    rsp_ready = 1'b0;
    check("rst_mid_no_activity", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
